cpu_sequencer: RTL
==================

# cpu_sequencer

Multi-cycle fetch/execute sequencer for the 16-bit CPU core. It fetches each instruction over a request/acknowledge port and holds it stable in the instruction register feeding the control unit. It qualifies register writes with a single commit pulse, handshakes data-memory writes for M destinations, and updates the program counter from the control unit's `set_pc`. It sits between instruction memory, the control unit, the register file and the data-memory write port.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `clk` in 1: single system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: level enable; the sequencer fetches while high.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out 16: fetch address, always equal to `pc`.
- `imem_ack` in 1: fetch data valid this cycle.
- `imem_rdata` in 16: instruction word.
- `ir` out 16: instruction register, drives control unit `instr`.
- `reg_commit` out 1: one-cycle qualifier ANDed with the control unit's A/D/M enables.
- `set_pc` in 1: registered jump decision from the control unit.
- `reg_a_in` in 16: current A register, used as the jump target.
- `dmem_wr_req` out 1: M write request.
- `dmem_ack` in 1: M write accepted.
- `pc` out 16: program counter.
- `retired` out 16: retired-instruction count.
- `halted` out 1: high in IDLE.
- `state` out 3: current FSM state, for debug.

## Operation
- FSM states and encodings:
  - IDLE=0: `halted`=1. Goes to FETCH when `run`=1.
  - FETCH=1: `imem_req`=1 until `imem_ack`. On ack, `ir`<=`imem_rdata` and go to DECODE.
  - DECODE=2: one cycle. The control unit registers x/y from `ir`. The sequencer latches `jump_target`<=`reg_a_in`.
  - EXECUTE=3: one cycle with `reg_commit`=1; the register file writes on the closing edge. The control unit registers `set_pc` on the same edge.
  - RESOLVE=4: `take_jump`<=`set_pc`, sampled only here. The M-write condition is `ir[15]`=0 and `ir[12]`=1.
    - M write: assert `dmem_wr_req` and go to MEMWAIT.
    - Otherwise: update the PC and retire.
  - MEMWAIT=5: hold `dmem_wr_req` until `dmem_ack`, then update the PC and retire.
- PC update: `pc`<=`take_jump` ? `jump_target` : `pc`+1. Arithmetic is modulo 2^16, so 16'hFFFF+1 = 16'h0000.
- Retire: `retired` increments by 1 (wraps at 2^16). Next state is FETCH if `run`=1, else IDLE.
- A-instructions (`ir[15]`=1) follow the same path. `set_pc` is 0 for them and there is never an M write.
- Dropping `run` mid-instruction has no effect until retire; the current instruction always completes.
- Encodings 6 and 7 are illegal; the FSM goes to IDLE on the next edge.

## Timing
- Reset values:
  - `state`=IDLE, `pc`=`RESET_PC`, `ir`=0, `retired`=0, `halted`=1.
  - `imem_req`=0, `dmem_wr_req`=0, `reg_commit`=0, and internal `take_jump`=0.
- Reset asserted mid-operation clears everything immediately, with no wait for a clock edge. Requests drop and any pending handshake is abandoned.
- Latency with zero-wait memory: 4 cycles per instruction (FETCH, DECODE, EXECUTE, RESOLVE). An M write adds 1 cycle plus the ack wait.
- FETCH and MEMWAIT are each 1 cycle when ack arrives in the cycle the request is raised. Ack is only sampled while the matching request is high; a stray ack is ignored.
- Requests stay asserted, with `imem_addr` stable, until acked. `ir` stays stable from DECODE through retire.
- `reg_commit` is high for exactly one cycle per instruction.

## Configuration
- `CPU_SEQ_STEP_EN` defined:
  - Adds input `step` (1 bit).
  - In IDLE with `run`=0, a `step` high for one cycle executes exactly one instruction and then returns to IDLE.
  - `step` is ignored outside IDLE. `run`=1 has priority over `step`.
- Undefined: no `step` port; only `run` leaves IDLE.

## Structure
- The shared package `cpu_pkg` holds:
  - state encoding constants (IDLE..MEMWAIT);
  - instruction field positions: type bit 15 and M-dest bit 12;
  - the `RESET_PC` default.
- No sub-module: the FSM, PC and retire counter stay in one module.

## Test plan
- Reset: assert `rst` mid-FETCH -> immediately `imem_req`=0, `pc`=0, `halted`=1, `state`=0.
- Straight line: `run`=1, zero-wait imem supplying @2, D=A, @3 -> `pc` goes 0,1,2,3 every 4 cycles; `reg_commit` pulses once per instruction; `retired`=3.
- Jump taken: `ir`=16'h0007 with `reg_a_in`=16'h0040 at DECODE and `set_pc`=1 in RESOLVE -> next `imem_addr`=16'h0040.
- M write: M=D instruction, `dmem_ack` delayed 3 cycles -> `dmem_wr_req` held for 4 cycles; `pc` increments only after ack; instruction takes 8 cycles.
- Run drop and wrap: `RESET_PC`=16'hFFFF, `run` pulsed for 1 cycle -> one instruction completes, `pc`=16'h0000, IDLE, `halted`=1.
- `CPU_SEQ_STEP_EN`: 2 step pulses with `run`=0 -> `retired`=2, IDLE between the pulses.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU core: sequencer state encodings,
// instruction field positions and the default reset PC.
package cpu_pkg;

   localparam int WORD_W = 16;
   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] ST_FETCH   = 3'd1;
   localparam logic [STATE_W-1:0] ST_DECODE  = 3'd2;
   localparam logic [STATE_W-1:0] ST_EXECUTE = 3'd3;
   localparam logic [STATE_W-1:0] ST_RESOLVE = 3'd4;
   localparam logic [STATE_W-1:0] ST_MEMWAIT = 3'd5;

   localparam int TYPE_BIT  = 15;
   localparam int MDEST_BIT = 12;

   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

   // A-instructions carry the type bit set; they never write memory.
   function automatic logic is_a_instr(input logic [WORD_W-1:0] instr);
      return instr[TYPE_BIT];
   endfunction

   function automatic logic is_m_write(input logic [WORD_W-1:0] instr);
      return !instr[TYPE_BIT] && instr[MDEST_BIT];
   endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute/resolve sequencer with PC and retire counter.
// Optional single-step input enabled by defining CPU_SEQ_STEP_EN.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
`ifdef CPU_SEQ_STEP_EN
   input  logic               step,
`endif
   output logic               imem_req,
   output logic [WORD_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [WORD_W-1:0]  imem_rdata,
   output logic [WORD_W-1:0]  ir,
   output logic               reg_commit,
   input  logic               set_pc,
   input  logic [WORD_W-1:0]  reg_a_in,
   output logic               dmem_wr_req,
   input  logic               dmem_ack,
   output logic [WORD_W-1:0]  pc,
   output logic [WORD_W-1:0]  retired,
   output logic               halted,
   output logic [STATE_W-1:0] state
);

   logic [STATE_W-1:0] state_nxt;
   logic [WORD_W-1:0]  jump_target;
   logic               take_jump;
   logic               leave_idle;
   logic               m_write;
   logic               retire;
   logic               jump_now;

   function automatic logic [WORD_W-1:0] next_pc(input logic jump,
                                                 input logic [WORD_W-1:0] target,
                                                 input logic [WORD_W-1:0] cur);
      return jump ? target : cur + 16'd1;
   endfunction

`ifdef CPU_SEQ_STEP_EN
   // run outranks step; both only matter while idle.
   assign leave_idle = run | step;
`else
   assign leave_idle = run;
`endif

   assign m_write = is_m_write(ir);

   // In RESOLVE the jump decision arrives directly from the control unit;
   // by MEMWAIT it has been captured into take_jump.
   assign jump_now = (state == ST_RESOLVE) ? set_pc : take_jump;

   assign retire = ((state == ST_RESOLVE) && !m_write) ||
                   ((state == ST_MEMWAIT) && dmem_ack);

   assign imem_addr = pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (leave_idle) state_nxt = ST_FETCH;
         ST_FETCH:   if (imem_ack) state_nxt = ST_DECODE;
         ST_DECODE:  state_nxt = ST_EXECUTE;
         ST_EXECUTE: state_nxt = ST_RESOLVE;
         ST_RESOLVE: begin
            if (m_write) state_nxt = ST_MEMWAIT;
            else         state_nxt = run ? ST_FETCH : ST_IDLE;
         end
         ST_MEMWAIT: if (dmem_ack) state_nxt = run ? ST_FETCH : ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      imem_req    = (state == ST_FETCH);
      reg_commit  = (state == ST_EXECUTE);
      dmem_wr_req = (state == ST_MEMWAIT);
      halted      = (state == ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir        <= '0;
         pc        <= RESET_PC;
         retired   <= '0;
         take_jump <= 1'b0;
      end else begin
         if ((state == ST_FETCH) && imem_ack) ir <= imem_rdata;
         if (state == ST_RESOLVE) take_jump <= set_pc;
         if (retire) begin
            pc      <= next_pc(jump_now, jump_target, pc);
            retired <= retired + 16'd1;
         end
      end
   end

   // Jump target is pure data: captured while the control unit decodes.
   always_ff @(posedge clk) begin
      if (state == ST_DECODE) jump_target <= reg_a_in;
   end

endmodule
